mod_updown_counter: RTL

- Synchronous, parametrised successor to the 4-bit ripple counter: WIDTH-bit counter with programmable modulus, up/down direction, programmable step, parallel load, synchronous clear, and wrap or saturate mode.
- Provides a combinational terminal-count output for cascading and a registered wrap/saturate event pulse.
- Used as the general-purpose counter and timebase in lab designs.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/mod_step_unit.sv | 69 ++++++
 rtl/mod_updown_counter.sv | 87 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modular up/down counter.
// Direction/mode encodings and a width sizing function.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  localparam int WRAP = 0;
  localparam int SAT  = 1;

  // Smallest width w (>= 1) such that 2**w >= mod.
  function automatic int min_width(input int mod);
    int w;
    w = 1;
    while (w < 31 && (1 << w) < mod)
      w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mod_step_unit.sv
// Combinational modular step: next value and wrap/clamp event.
// Intermediates are WIDTH+1 bits so no sum can overflow.
module mod_step_unit
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH-1:0] i_step,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next,
  output logic             o_evt
);

  localparam logic [WIDTH:0] LP_MOD = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] LP_MAX = (WIDTH+1)'(MOD - 1);

  logic [WIDTH:0] w_cnt;
  logic [WIDTH:0] w_step;
  logic [WIDTH:0] w_eff;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_up_wrap;
  logic [WIDTH:0] w_dn;
  logic [WIDTH:0] w_dn_wrap;
  logic [WIDTH:0] w_nxt;

  // Reduce step and form every candidate result.
  always_comb begin
    w_cnt     = {1'b0, i_count};
    w_step    = {1'b0, i_step};
    w_eff     = w_step % LP_MOD;
    w_sum     = w_cnt + w_eff;
    w_up_wrap = w_sum - LP_MOD;
    w_dn      = w_cnt - w_eff;
    w_dn_wrap = w_cnt + LP_MOD - w_eff;
  end

  // Select the next count and flag a wrap or clamp.
  always_comb begin
    w_nxt = w_cnt;
    o_evt = 1'b0;
    if (i_up == CNT_UP) begin
      if (w_sum < LP_MOD) begin
        w_nxt = w_sum;
      end else begin
        o_evt = 1'b1;
        if (SATURATE == SAT)
          w_nxt = LP_MAX;
        else
          w_nxt = w_up_wrap;
      end
    end else begin
      if (w_cnt >= w_eff) begin
        w_nxt = w_dn;
      end else begin
        o_evt = 1'b1;
        if (SATURATE == SAT)
          w_nxt = '0;
        else
          w_nxt = w_dn_wrap;
      end
    end
  end

  assign o_next = WIDTH'(w_nxt);

endmodule

// File: rtl/mod_updown_counter.sv
// Modular up/down counter with load, clear, wrap or saturate.
// Register, control priority, load clamping and terminal count.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter int SATURATE = 0,
  parameter int RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt,
  output logic             load_err
);

  if (WIDTH < 2 || WIDTH > 16 || MOD < 2 ||
      WIDTH < min_width(MOD) ||
      RST_VAL < 0 || RST_VAL >= MOD) begin : g_bad_cfg
    $fatal(1, "mod_updown_counter: bad WIDTH/MOD/RST_VAL");
  end

  localparam logic [WIDTH:0]   LP_MOD  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] LP_RST  = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_evt;
  logic             r_lerr;
  logic [WIDTH-1:0] w_next;
  logic             w_evt;
  logic             w_ld_ok;

  mod_step_unit #(
    .WIDTH    (WIDTH),
    .MOD      (MOD),
    .SATURATE (SATURATE)
  ) u_step (
    .i_count (r_count),
    .i_step  (step),
    .i_up    (up),
    .o_next  (w_next),
    .o_evt   (w_evt)
  );

  assign w_ld_ok = ({1'b0, load_val} < LP_MOD);

  // Count register: clr beats load beats en beats hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= LP_RST;
      r_evt   <= 1'b0;
      r_lerr  <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_evt   <= 1'b0;
      r_lerr  <= 1'b0;
    end else if (load) begin
      r_count <= w_ld_ok ? load_val : LP_MAX;
      r_evt   <= 1'b0;
      r_lerr  <= ~w_ld_ok;
    end else if (en) begin
      r_count <= w_next;
      r_evt   <= w_evt;
      r_lerr  <= 1'b0;
    end else begin
      r_evt   <= 1'b0;
      r_lerr  <= 1'b0;
    end
  end

  assign count    = r_count;
  assign evt      = r_evt;
  assign load_err = r_lerr;

  assign tc = en & ((up  & (r_count == LP_MAX)) |
                    (~up & (r_count == '0)));

endmodule
